// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared types and constants for the fetch controller: the
//               controller state enumeration and the statistics counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

  // Width of both statistics counters.
  localparam int STAT_W = 16;

  // Controller states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Bundle of pipeline-control signals between the hazard / EX /
//               debug logic (master) and the fetch controller (slave).
//   master -> slave : hazard_stall, redirect_req, redirect_target,
//                     halt_req, step_req
//   slave -> master : pc_write, ifid_write, ifid_flush, pc_src, redirect_pc,
//                     halted, stat_stall_cnt, stat_flush_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int XLEN = 32
);
  logic              hazard_stall;
  logic              redirect_req;
  logic [XLEN-1:0]   redirect_target;
  logic              halt_req;
  logic              step_req;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              pc_src;
  logic [XLEN-1:0]   redirect_pc;
  logic              halted;
  logic [STAT_W-1:0] stat_stall_cnt;
  logic [STAT_W-1:0] stat_flush_cnt;

  modport master (
    output hazard_stall, redirect_req, redirect_target, halt_req, step_req,
    input  pc_write, ifid_write, ifid_flush, pc_src, redirect_pc, halted,
           stat_stall_cnt, stat_flush_cnt
  );

  modport slave (
    input  hazard_stall, redirect_req, redirect_target, halt_req, step_req,
    output pc_write, ifid_write, ifid_flush, pc_src, redirect_pc, halted,
           stat_stall_cnt, stat_flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value.
//   clk   - clock
//   clear - synchronous clear (highest priority)
//   inc   - increment enable
//   count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             clear,
  input  wire logic             inc,
  output logic      [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Front-end fetch controller. Sequences boot hold, normal fetch,
//               debug halt and single-step; arbitrates redirects against
//               load-use stalls and keeps stall / flush statistics.
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_ctrl_if slave modport (control inputs, fetch enables,
//          redirect target, halted flag, statistics)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BOOT_CYCLES = 2
) (
  input wire logic  clk,
  input wire logic  rst,
  fetch_ctrl_if.slave bus
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  fetch_state_t    state, state_nx;
  logic [3:0]      boot_cnt, boot_cnt_nx;
  logic            pending_valid, pending_valid_nx;
  logic [XLEN-1:0] pending_pc, pending_pc_nx;
  logic            stall_inc;
  logic            flush_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      boot_cnt      <= '0;
      pending_valid <= 1'b0;
      pending_pc    <= '0;
    end else begin
      state         <= state_nx;
      boot_cnt      <= boot_cnt_nx;
      pending_valid <= pending_valid_nx;
      pending_pc    <= pending_pc_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    boot_cnt_nx      = boot_cnt;
    pending_valid_nx = pending_valid;
    pending_pc_nx    = pending_pc;
    bus.pc_write     = 1'b0;
    bus.ifid_write   = 1'b0;
    bus.ifid_flush   = 1'b0;
    bus.pc_src       = 1'b0;
    bus.redirect_pc  = '0;
    bus.halted       = 1'b0;
    stall_inc        = 1'b0;

    if (rst) begin
      // The state register may still hold anything while reset is first
      // sampled, so present the boot outputs directly.
      bus.ifid_flush = 1'b1;
    end else begin
      case (state)
        BOOT: begin
          bus.ifid_flush = 1'b1;
          boot_cnt_nx    = boot_cnt + 1'b1;
          if (bus.redirect_req) begin
            pending_valid_nx = 1'b1;
            pending_pc_nx    = bus.redirect_target;
          end
          if (boot_cnt == BOOT_LAST) begin
            state_nx = RUN;
          end
        end

        HALT: begin
          bus.halted = 1'b1;
          if (bus.redirect_req) begin
            pending_valid_nx = 1'b1;
            pending_pc_nx    = bus.redirect_target;
          end
          if (bus.step_req) begin
            state_nx = STEP;
          end else if (!bus.halt_req) begin
            state_nx = RUN;
          end
        end

        default: begin // RUN or STEP: one fetch cycle
          if (pending_valid) begin
            // Redirect parked while halted/booting wins over a live one.
            bus.pc_write     = 1'b1;
            bus.ifid_write   = 1'b1;
            bus.ifid_flush   = 1'b1;
            bus.pc_src       = 1'b1;
            bus.redirect_pc  = pending_pc;
            pending_valid_nx = 1'b0;
          end else if (bus.redirect_req) begin
            bus.pc_write    = 1'b1;
            bus.ifid_write  = 1'b1;
            bus.ifid_flush  = 1'b1;
            bus.pc_src      = 1'b1;
            bus.redirect_pc = bus.redirect_target;
          end else if (bus.hazard_stall) begin
            stall_inc = 1'b1;
          end else begin
            bus.pc_write   = 1'b1;
            bus.ifid_write = 1'b1;
          end

          if ((state == STEP) || bus.halt_req) begin
            state_nx = HALT;
          end
        end
      endcase
    end
  end

  assign flush_inc = bus.ifid_flush & ~rst;

  sat_counter #(.WIDTH(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_inc),
    .count (bus.stat_stall_cnt)
  );

  sat_counter #(.WIDTH(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (flush_inc),
    .count (bus.stat_flush_cnt)
  );

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 32, width of PC and redirect addresses.
REQ-002 Parameter BOOT_CYCLES, default 2, legal range 1..15, number of post-reset cycles in which fetch is held.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 hazard_stall  input  1  load-use stall request from hazard detection.
REQ-006 redirect_req  input  1  taken branch or jump resolved in EX.
REQ-007 redirect_target  input  XLEN  target address, valid when redirect_req=1.
REQ-008 halt_req  input  1  debug halt request, level-sensitive.
REQ-009 step_req  input  1  debug single-step pulse, honoured only in HALT.
REQ-010 pc_write  output  1  PC enable to the fetch stage.
REQ-011 ifid_write  output  1  IF/ID latch enable.
REQ-012 ifid_flush  output  1  IF/ID squash pulse.
REQ-013 pc_src  output  1  0 = PC+4, 1 = redirect_pc.
REQ-014 redirect_pc  output  XLEN  next-PC target.
REQ-015 halted  output  1  high while state is HALT.
REQ-016 stat_stall_cnt  output  16  saturating count of hazard-stall cycles.
REQ-017 stat_flush_cnt  output  16  saturating count of ifid_flush cycles.

Function
REQ-018 States: BOOT, RUN, HALT, STEP. pc_write, ifid_write, ifid_flush, pc_src and redirect_pc are combinational from state, pending register and inputs, with zero-cycle latency.
REQ-019 BOOT: pc_write=0, ifid_write=0, ifid_flush=1, pc_src=0; boot counter increments each cycle; transition to RUN after exactly BOOT_CYCLES cycles.
REQ-020 Fetch cycle (RUN or STEP), priority highest first:
- (a) pending_valid=1: pc_src=1, redirect_pc=pending_pc, ifid_flush=1, pending cleared.
- (b) redirect_req=1: pc_src=1, redirect_pc=redirect_target, ifid_flush=1.
- (c) hazard_stall=1: pc_write=0, ifid_write=0.
- (d) otherwise: pc_write=1, ifid_write=1, flush=0, pc_src=0.
REQ-021 In cases (a) and (b), pc_write=1 and ifid_write=1; a redirect overrides a simultaneous stall.
REQ-022 In case (a), a simultaneous redirect_req is dropped; the pending target has priority.
REQ-023 Whenever pc_src=0, redirect_pc shall equal 0.
REQ-024 In BOOT or HALT, redirect_req=1 captures redirect_target into pending_pc and sets pending_valid; a later capture overwrites an earlier one. The redirect is not applied in that cycle.
REQ-025 RUN with halt_req=1: the REQ-020 action is still performed this cycle, then next state is HALT.
REQ-026 HALT: pc_write=0, ifid_write=0, ifid_flush=0, halted=1.
- step_req=1 -> STEP (step_req has priority over halt_req=0).
- halt_req=0 and step_req=0 -> RUN.
REQ-027 STEP: exactly one fetch cycle per REQ-020, then unconditionally HALT. A stalled step consumes the step.
REQ-028 stat_stall_cnt increments in each fetch cycle that takes case (c); it saturates at 0xFFFF.
REQ-029 stat_flush_cnt increments in each cycle with ifid_flush=1, BOOT included; it saturates at 0xFFFF.

Reset
REQ-030 With rst=1 at a clock edge: state=BOOT, boot counter=0, pending_valid=0, pending_pc=0, both stat counters=0.
REQ-031 Output values during and immediately after reset: the BOOT values (pc_write=0, ifid_write=0, ifid_flush=1, pc_src=0, redirect_pc=0, halted=0).
REQ-032 Reset asserted mid-operation (HALT with a pending redirect, or STEP) discards all state within one cycle.

Structure
REQ-033 Shared package holds the state enum fetch_state_t (BOOT, RUN, HALT, STEP) and the 16-bit stat width constant.
REQ-034 Single module. Natural sub-module: sat_counter (width parameter, inc, clear), instantiated twice.

Verification
REQ-035 Reset release, BOOT_CYCLES=2 -> ifid_flush=1 and pc_write=0 for exactly 2 cycles; first RUN cycle pc_write=1; stat_flush_cnt=2.
REQ-036 RUN: hazard_stall=1 for 3 cycles -> pc_write=ifid_write=0 for those 3 cycles; stat_stall_cnt=3.
REQ-037 RUN: hazard_stall=1 and redirect_req=1 with target 0x0000_0040 in the same cycle -> pc_src=1, redirect_pc=0x40, ifid_flush=1 for one cycle, pc_write=1; stall count unchanged.
REQ-038 HALT: redirect 0x100, then redirect 0x200, then halt_req=0 -> first RUN cycle pc_src=1, redirect_pc=0x200, ifid_flush=1; next cycle pc_src=0.
REQ-039 HALT: step_req pulse -> exactly one cycle of pc_write=1, then halted=1 again; with hazard_stall=1 during the step, pc_write stays 0 and the bench sees HALT.
REQ-040 Force both counters to 0xFFFE, then apply 3 stall cycles -> stat_stall_cnt=0xFFFF with no wrap; rst=1 -> both counters=0.
